// File: rtl/tracker_controller.sv
// Purpose: line-following sequencer; debounces {left,mid,right} and drives motor command and wheel duties.
// Latency: a stable sensor change reaches the outputs STABLE_CYCLES+1 cycles later; all outputs registered.
// Backpressure: none, sensor is sampled every cycle and outputs are level commands.
// Optional feature: TRACKER_SEARCH_EN adds the SEARCH/HALT recovery behaviour and the lost flag.
module tracker_controller #(
  parameter int DUTY_W        = 10,
  parameter int FAST_DUTY     = 800,
  parameter int SLOW_DUTY     = 400,
  parameter int STABLE_CYCLES = 4,
  parameter int SEARCH_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [2:0]        sensor_state,
  output logic [1:0]        motor_cmd,
  output logic [DUTY_W-1:0] left_duty,
  output logic [DUTY_W-1:0] right_duty,
  output logic              lost
);

  // Reject nonsensical overrides at elaboration time.
  if (STABLE_CYCLES < 1 || SEARCH_CYCLES < 2) begin : g_param_check
    $error("tracker_controller: need STABLE_CYCLES >= 1 and SEARCH_CYCLES >= 2");
  end

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FOLLOW = 2'd1;
`ifdef TRACKER_SEARCH_EN
  localparam logic [1:0] ST_SEARCH = 2'd2;
  localparam logic [1:0] ST_HALT   = 2'd3;
`endif

  localparam logic [1:0] CMD_STOP  = 2'd0;
  localparam logic [1:0] CMD_FWD   = 2'd1;
  localparam logic [1:0] CMD_LEFT  = 2'd2;
  localparam logic [1:0] CMD_RIGHT = 2'd3;

  localparam logic [DUTY_W-1:0] FAST = FAST_DUTY[DUTY_W-1:0];
  localparam logic [DUTY_W-1:0] SLOW = SLOW_DUTY[DUTY_W-1:0];
  localparam logic [DUTY_W-1:0] ZERO = '0;

  localparam int FCW = $clog2(STABLE_CYCLES + 1);
  localparam logic [FCW-1:0] F_SAT = FCW'(STABLE_CYCLES);

  logic [1:0]        state, state_nxt;
  logic [2:0]        cand, filt;
  logic [FCW-1:0]    fcnt, fcnt_nxt;
  logic [1:0]        map_cmd, cmd_nxt;
  logic [DUTY_W-1:0] map_l, map_r, l_nxt, r_nxt;

`ifdef TRACKER_SEARCH_EN
  localparam int SCW = $clog2(SEARCH_CYCLES);
  localparam logic [SCW-1:0] SC_TERM = SCW'(SEARCH_CYCLES - 1);

  logic [SCW-1:0]    scnt, scnt_nxt;
  logic              last_side;  // 0 = line last seen on the left, 1 = right
  logic              lost_nxt;
  logic [1:0]        piv_cmd;
  logic [DUTY_W-1:0] piv_l, piv_r;
`endif

  // Run length of the current candidate pattern, saturating once it is accepted.
  always_comb begin
    fcnt_nxt = FCW'(1);
    if (sensor_state == cand) begin
      fcnt_nxt = (fcnt == F_SAT) ? fcnt : fcnt + 1'b1;
    end
  end

  // Debounce: filt only takes a pattern seen on STABLE_CYCLES consecutive edges.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cand <= 3'b000;
      fcnt <= '0;
      filt <= 3'b000;
    end else begin
      cand <= sensor_state;
      fcnt <= fcnt_nxt;
      if (fcnt_nxt == F_SAT) begin
        filt <= sensor_state;
      end
    end
  end

  // Line-following map; 101 and 000 fall through to "hold" and 000 is handled by the FSM.
  always_comb begin
    map_cmd = motor_cmd;
    map_l   = left_duty;
    map_r   = right_duty;
    case (filt)
      3'b010, 3'b111: begin map_cmd = CMD_FWD;   map_l = FAST; map_r = FAST; end
      3'b110:         begin map_cmd = CMD_LEFT;  map_l = SLOW; map_r = FAST; end
      3'b100:         begin map_cmd = CMD_LEFT;  map_l = ZERO; map_r = FAST; end
      3'b011:         begin map_cmd = CMD_RIGHT; map_l = FAST; map_r = SLOW; end
      3'b001:         begin map_cmd = CMD_RIGHT; map_l = FAST; map_r = ZERO; end
      default:        begin map_cmd = motor_cmd; map_l = left_duty; map_r = right_duty; end
    endcase
  end

`ifdef TRACKER_SEARCH_EN
  // Pivot on the spot toward the side where the line was last seen.
  always_comb begin
    piv_cmd = last_side ? CMD_RIGHT : CMD_LEFT;
    piv_l   = last_side ? FAST : ZERO;
    piv_r   = last_side ? ZERO : FAST;
  end
`endif

  // Next state and next registered outputs; enable low overrides everything.
  always_comb begin
    state_nxt = state;
    cmd_nxt   = motor_cmd;
    l_nxt     = left_duty;
    r_nxt     = right_duty;
`ifdef TRACKER_SEARCH_EN
    lost_nxt  = 1'b0;
    scnt_nxt  = scnt;
`endif
    if (!enable) begin
      state_nxt = ST_IDLE;
      cmd_nxt   = CMD_STOP;
      l_nxt     = ZERO;
      r_nxt     = ZERO;
    end else begin
      case (state)
        ST_IDLE: begin
          // Outputs pick up the map one edge after entering FOLLOW.
          state_nxt = ST_FOLLOW;
          cmd_nxt   = CMD_STOP;
          l_nxt     = ZERO;
          r_nxt     = ZERO;
        end
        ST_FOLLOW: begin
          if (filt == 3'b000) begin
`ifdef TRACKER_SEARCH_EN
            state_nxt = ST_SEARCH;
            scnt_nxt  = '0;
            cmd_nxt   = piv_cmd;
            l_nxt     = piv_l;
            r_nxt     = piv_r;
`else
            cmd_nxt   = CMD_STOP;
            l_nxt     = ZERO;
            r_nxt     = ZERO;
`endif
          end else begin
            cmd_nxt = map_cmd;
            l_nxt   = map_l;
            r_nxt   = map_r;
          end
        end
`ifdef TRACKER_SEARCH_EN
        ST_SEARCH: begin
          // Reacquisition is tested first so it wins over the timeout.
          if (filt != 3'b000) begin
            state_nxt = ST_FOLLOW;
            cmd_nxt   = map_cmd;
            l_nxt     = map_l;
            r_nxt     = map_r;
          end else if (scnt == SC_TERM) begin
            state_nxt = ST_HALT;
            cmd_nxt   = CMD_STOP;
            l_nxt     = ZERO;
            r_nxt     = ZERO;
            lost_nxt  = 1'b1;
          end else begin
            scnt_nxt  = scnt + 1'b1;
            cmd_nxt   = piv_cmd;
            l_nxt     = piv_l;
            r_nxt     = piv_r;
          end
        end
        ST_HALT: begin
          // Sensors are ignored; only dropping enable leaves HALT.
          cmd_nxt  = CMD_STOP;
          l_nxt    = ZERO;
          r_nxt    = ZERO;
          lost_nxt = 1'b1;
        end
`endif
        default: begin
          state_nxt = ST_IDLE;
          cmd_nxt   = CMD_STOP;
          l_nxt     = ZERO;
          r_nxt     = ZERO;
        end
      endcase
    end
  end

  // FSM state and registered motor outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      motor_cmd  <= CMD_STOP;
      left_duty  <= ZERO;
      right_duty <= ZERO;
    end else begin
      state      <= state_nxt;
      motor_cmd  <= cmd_nxt;
      left_duty  <= l_nxt;
      right_duty <= r_nxt;
    end
  end

`ifdef TRACKER_SEARCH_EN
  // Search timer, lost flag and last-seen side (only the pivot direction needs it).
  always_ff @(posedge clk) begin
    if (!reset) begin
      scnt      <= '0;
      lost      <= 1'b0;
      last_side <= 1'b0;
    end else begin
      scnt <= scnt_nxt;
      lost <= lost_nxt;
      case (filt)
        3'b100, 3'b110: last_side <= 1'b0;
        3'b001, 3'b011: last_side <= 1'b1;
        default:        last_side <= last_side;
      endcase
    end
  end
`else
  assign lost = 1'b0;
`endif

endmodule

// File: tb/tb_tracker_controller.sv
// Purpose: directed bench for tracker_controller (STABLE_CYCLES=4, SEARCH_CYCLES=16, default duties).
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: none; expectations follow TRACKER_SEARCH_EN the same way the design does.
module tb_tracker_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] sensor_state;
  logic [1:0] motor_cmd;
  logic [9:0] left_duty;
  logic [9:0] right_duty;
  logic       lost;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       en;
    logic [2:0] sens;
    int         edges;
    logic [1:0] cmd;
    logic [9:0] l;
    logic [9:0] r;
    logic       lo;
  } vec_t;

  vec_t vecs [16];

  always #5 clk = ~clk;

  tracker_controller #(
    .DUTY_W(10),
    .FAST_DUTY(800),
    .SLOW_DUTY(400),
    .STABLE_CYCLES(4),
    .SEARCH_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .sensor_state(sensor_state),
    .motor_cmd(motor_cmd),
    .left_duty(left_duty),
    .right_duty(right_duty),
    .lost(lost)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] c, input logic [9:0] l,
                       input logic [9:0] r, input logic lo);
    checks++;
    if (motor_cmd !== c || left_duty !== l || right_duty !== r || lost !== lo) begin
      errors++;
      $display("FAIL %s: got cmd=%0d l=%0d r=%0d lost=%0d, want cmd=%0d l=%0d r=%0d lost=%0d",
               name, motor_cmd, left_duty, right_duty, lost, c, l, r, lo);
    end
  endtask

  // Checks the outputs on every one of n consecutive edges.
  task automatic hold_check(input string name, input int n, input logic [1:0] c,
                            input logic [9:0] l, input logic [9:0] r, input logic lo);
    int bad = 0;
    for (int k = 0; k < n; k++) begin
      step(1);
      if (motor_cmd !== c || left_duty !== l || right_duty !== r || lost !== lo) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d of %0d cycles differed, want cmd=%0d l=%0d r=%0d lost=%0d on all",
               name, bad, n, c, l, r, lo);
    end
  endtask

  initial begin
    // {enable, sensor, edges to wait, cmd, left, right, lost}
    vecs[0]  = '{1'b1, 3'b010, 5, 2'd1, 10'd800, 10'd800, 1'b0}; // first pattern, 5 cycles
    vecs[1]  = '{1'b1, 3'b110, 3, 2'd1, 10'd800, 10'd800, 1'b0}; // short glitch
    vecs[2]  = '{1'b1, 3'b010, 5, 2'd1, 10'd800, 10'd800, 1'b0}; // glitch rejected
    vecs[3]  = '{1'b1, 3'b110, 4, 2'd1, 10'd800, 10'd800, 1'b0}; // accepted, output not yet
    vecs[4]  = '{1'b1, 3'b110, 1, 2'd2, 10'd400, 10'd800, 1'b0}; // gentle left
    vecs[5]  = '{1'b1, 3'b100, 5, 2'd2, 10'd0,   10'd800, 1'b0}; // hard left
    vecs[6]  = '{1'b1, 3'b101, 5, 2'd2, 10'd0,   10'd800, 1'b0}; // 101 holds
    vecs[7]  = '{1'b1, 3'b011, 5, 2'd3, 10'd800, 10'd400, 1'b0}; // gentle right
    vecs[8]  = '{1'b1, 3'b001, 5, 2'd3, 10'd800, 10'd0,   1'b0}; // hard right
    vecs[9]  = '{1'b1, 3'b111, 5, 2'd1, 10'd800, 10'd800, 1'b0}; // 111 forward
    vecs[10] = '{1'b0, 3'b111, 1, 2'd0, 10'd0,   10'd0,   1'b0}; // disable -> idle
    vecs[11] = '{1'b1, 3'b111, 1, 2'd0, 10'd0,   10'd0,   1'b0}; // enable edge: still stop
    vecs[12] = '{1'b1, 3'b111, 1, 2'd1, 10'd800, 10'd800, 1'b0}; // next edge: follow map
    vecs[13] = '{1'b1, 3'b110, 5, 2'd2, 10'd400, 10'd800, 1'b0}; // sets last side left
    vecs[14] = '{1'b1, 3'b000, 4, 2'd2, 10'd400, 10'd800, 1'b0}; // filt just became 000
    vecs[15] = '{1'b1, 3'b000, 0, 2'd2, 10'd400, 10'd800, 1'b0}; // no-op re-check

    reset        = 1'b0;
    enable       = 1'b0;
    sensor_state = 3'b000;
    step(2);
    check("reset", 2'd0, 10'd0, 10'd0, 1'b0);

    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      enable       = vecs[i].en;
      sensor_state = vecs[i].sens;
      step(vecs[i].edges);
      check($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].l, vecs[i].r, vecs[i].lo);
    end

`ifdef TRACKER_SEARCH_EN
    // Line lost after 110: pivot left, then timeout into HALT.
    step(1);
    check("search_enter", 2'd2, 10'd0, 10'd800, 1'b0);
    hold_check("search_run", 15, 2'd2, 10'd0, 10'd800, 1'b0);
    step(1);
    check("halt_timeout", 2'd0, 10'd0, 10'd0, 1'b1);
    sensor_state = 3'b010;
    hold_check("halt_ignores_sensor", 10, 2'd0, 10'd0, 10'd0, 1'b1);
    enable = 1'b0;
    step(1);
    check("halt_to_idle", 2'd0, 10'd0, 10'd0, 1'b0);
    enable = 1'b1;
    step(1);
    check("idle_to_follow", 2'd0, 10'd0, 10'd0, 1'b0);
    step(1);
    check("resume_fwd", 2'd1, 10'd800, 10'd800, 1'b0);

    // Reacquire during search toward the right.
    sensor_state = 3'b011;
    step(5);
    check("right_gentle", 2'd3, 10'd800, 10'd400, 1'b0);
    sensor_state = 3'b000;
    step(5);
    check("search_right", 2'd3, 10'd800, 10'd0, 1'b0);
    sensor_state = 3'b001;
    hold_check("reacquire", 25, 2'd3, 10'd800, 10'd0, 1'b0);
    sensor_state = 3'b010;
    step(5);
    check("reacquire_fwd", 2'd1, 10'd800, 10'd800, 1'b0);

    // Reset in the middle of a search, then search/halt from reset defaults.
    sensor_state = 3'b000;
    step(5);
    check("search_again", 2'd3, 10'd800, 10'd0, 1'b0);
    step(3);
    reset = 1'b0;
    step(1);
    check("reset_in_search", 2'd0, 10'd0, 10'd0, 1'b0);
    reset = 1'b1;
    step(2);
    check("search_from_reset", 2'd2, 10'd0, 10'd800, 1'b0);
    step(16);
    check("halt_from_reset", 2'd0, 10'd0, 10'd0, 1'b1);
    reset = 1'b0;
    step(1);
    check("reset_in_halt", 2'd0, 10'd0, 10'd0, 1'b0);
    reset = 1'b1;
`else
    // No search: losing the line stops the car without ever flagging lost.
    step(1);
    check("line_lost_stop", 2'd0, 10'd0, 10'd0, 1'b0);
    hold_check("stop_held", 100, 2'd0, 10'd0, 10'd0, 1'b0);
    sensor_state = 3'b010;
    step(5);
    check("resume_fwd", 2'd1, 10'd800, 10'd800, 1'b0);
    reset = 1'b0;
    step(1);
    check("reset_mid_run", 2'd0, 10'd0, 10'd0, 1'b0);
    reset = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tracker_controller.md
# tracker_controller

Line-following sequencer for the car. It debounces the 3-bit tracker pattern `{left, mid, right}` and runs a follow / search / halt state machine. It drives the motor direction command and the per-wheel PWM duty values consumed by the motor block. It sits between the tracker sensor front end and the motor/PWM driver.

## Interface
- `DUTY_W`, 10, width of the duty outputs.
- `FAST_DUTY`, 800, duty for the outer/straight wheel.
- `SLOW_DUTY`, 400, duty for the inner wheel on a gentle turn.
- `STABLE_CYCLES`, 4, consecutive identical samples required to accept a pattern (≥1).
- `SEARCH_CYCLES`, 1000000, maximum search duration in cycles (≥2).

Ports:
- `clk` in 1 — single system clock; every register is updated on its rising edge.
- `reset` in 1 — synchronous, active-low reset.
- `enable` in 1 — run request; low forces IDLE.
- `sensor_state` in 3 — `{left, mid, right}`, where 1 means line detected.
- `motor_cmd` out 2 — 0 STOP, 1 FORWARD, 2 TURN_LEFT, 3 TURN_RIGHT.
- `left_duty` out DUTY_W — left wheel duty.
- `right_duty` out DUTY_W — right wheel duty.
- `lost` out 1 — high while in HALT.

## Operation
- **Filter:**
  - `sensor_state` is sampled every cycle.
  - The filtered pattern `filt` changes to V only after V has been sampled on `STABLE_CYCLES` consecutive edges.
  - Any differing sample restarts the count.
- **last_side register:**
  - Set to LEFT on `filt` 100 or 110.
  - Set to RIGHT on `filt` 001 or 011.
  - Unchanged otherwise.
- **FSM states:** IDLE, FOLLOW, SEARCH, HALT.
- **IDLE:**
  - Outputs STOP, duties 0.
  - Goes to FOLLOW when `enable`=1.
- **FOLLOW** (mapping from `filt`; duties given as left/right):
  - 010 or 111 → FORWARD, FAST/FAST.
  - 110 → TURN_LEFT, SLOW/FAST.
  - 100 → TURN_LEFT, 0/FAST.
  - 011 → TURN_RIGHT, FAST/SLOW.
  - 001 → TURN_RIGHT, FAST/0.
  - 101 → hold the previous command and duties.
  - 000 → go to SEARCH with the search counter cleared.
- **SEARCH:**
  - Pivots toward `last_side`: LEFT gives TURN_LEFT 0/FAST; RIGHT gives TURN_RIGHT FAST/0.
  - The counter increments every cycle.
  - If `filt` ≠ 000, go to FOLLOW.
  - Otherwise, when the counter reaches `SEARCH_CYCLES`-1, go to HALT.
  - If both conditions hold on the same edge, line reacquisition wins.
- **HALT:**
  - Outputs STOP, duties 0, `lost`=1.
  - Sensor activity is ignored.
  - Left only when `enable`=0.
- **Enable priority:** `enable`=0 in any state moves to IDLE on the next edge. This overrides every other transition.
- **Counter width:** the search counter is `$clog2(SEARCH_CYCLES)` bits and never wraps; it holds at terminal.
- **Filter counter:** saturates at `STABLE_CYCLES`.

## Timing
- All outputs are registered.
- Latency from a stable `sensor_state` change to the output update is `STABLE_CYCLES`+1 cycles.
- Reset (`reset`=0 at an edge) produces:
  - state IDLE;
  - `motor_cmd`=0, `left_duty`=0, `right_duty`=0, `lost`=0;
  - `filt`=000, `last_side`=LEFT;
  - filter count 0, search counter 0.
- Reset asserted mid-search or mid-halt takes effect on that edge. No output glitch or held state survives it.
- With `enable` rising at edge n: FSM is in FOLLOW after edge n; outputs follow the FOLLOW mapping of the current `filt` after edge n+1.
- The FOLLOW→SEARCH outputs change one cycle after `filt` becomes 000.

## Configuration
- `TRACKER_SEARCH_EN` defined:
  - SEARCH state as described above.
- Not defined:
  - SEARCH and its counter are removed.
  - `filt`=000 in FOLLOW outputs STOP, duties 0, and stays in FOLLOW.
  - Motion resumes per the mapping when the line returns.
  - HALT is unreachable and `lost` is tied 0.

## Test plan
Bench overrides: `STABLE_CYCLES`=4, `SEARCH_CYCLES`=16, default duties.
- Reset release, `enable`=1, `sensor_state`=010 held → `motor_cmd`=1 and duties 800/800 appear 5 cycles after the pattern starts; `lost`=0.
- 010 then 110 held 3 cycles then back to 010 → output stays FORWARD (glitch rejected).
- 010 held, then 110 held, then 100 held → TURN_LEFT 400/800, then TURN_LEFT 0/800.
- `TRACKER_SEARCH_EN` defined, after 100 → 000 → SEARCH (`motor_cmd`=2, 0/800); after 16 cycles → `lost`=1, STOP, 0/0. `enable`=0 → IDLE; `enable`=1 with 010 → FORWARD.
- In SEARCH, 001 presented for 4 cycles before timeout → FOLLOW with TURN_RIGHT 800/0, `lost` never asserted.
- `reset`=0 for one edge during SEARCH → all outputs 0 next cycle. `TRACKER_SEARCH_EN` undefined, 000 held 100 cycles → STOP with `lost`=0 throughout.
